// File: rtl/heart_ctrl_pkg.sv
// Shared constants for the fight-phase heart controller and the bullet generator.
package heart_ctrl_pkg;

    localparam logic [7:0] KEY_W = 8'h77;
    localparam logic [7:0] KEY_A = 8'h61;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_D = 8'h64;

    localparam logic [1:0] COL_WHITE = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_BLUE  = 2'd2;
    localparam logic [1:0] COL_NONE  = 2'd3;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_MOVE  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    // Pending-move bit positions
    localparam int P_U = 3;
    localparam int P_D = 2;
    localparam int P_L = 1;
    localparam int P_R = 0;

    localparam logic [7:0] MIN_POS = 8'd8;
    localparam logic [7:0] MAX_POS = 8'd192;

    // |a - b| for 8-bit box coordinates, using a 9-bit two's-complement difference
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[8]) begin
            return 9'd0 - d;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/heart_ctrl_axis_step_clamp.sv
// One axis of heart motion: step by +/-STEP, clamp to the play box, flag a change.
module axis_step_clamp
    import heart_ctrl_pkg::*;
#(
    parameter logic [7:0] LO   = MIN_POS,
    parameter logic [7:0] HI   = MAX_POS,
    parameter logic [7:0] STEP = 8'd4
) (
    input  logic [7:0] pos_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] next_pos_o,
    output logic       changed_o
);

    logic [9:0] raw_s;

    // Widened step so that neither end of the box can wrap before clamping
    always_comb begin
        raw_s = {2'b00, pos_i};
        if (inc_i && !dec_i) begin
            raw_s = {2'b00, pos_i} + {2'b00, STEP};
        end else if (dec_i && !inc_i) begin
            raw_s = {2'b00, pos_i} - {2'b00, STEP};
        end else begin
            raw_s = {2'b00, pos_i};
        end

        if (raw_s[9]) begin
            next_pos_o = LO;
        end else if (raw_s < {2'b00, LO}) begin
            next_pos_o = LO;
        end else if (raw_s > {2'b00, HI}) begin
            next_pos_o = HI;
        end else begin
            next_pos_o = raw_s[7:0];
        end
    end

    assign changed_o = (next_pos_o != pos_i);

endmodule

// File: rtl/heart_ctrl.sv
// Player heart controller for the fight phase: frame-paced movement inside the
// play box, bullet collision, damage/heal pulses and invulnerability window.
module heart_ctrl
    import heart_ctrl_pkg::*;
#(
    parameter logic [7:0] START_X   = 8'd100,
    parameter logic [7:0] START_Y   = 8'd100,
    parameter logic [7:0] STEP      = 8'd4,
    parameter logic [7:0] HIT_HALF  = 8'd16,
    parameter logic [7:0] BLUE_HALF = 8'd58,
    parameter int         IFRAMES   = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        key_ready,
    input  logic        bullet_active,
    input  logic [15:0] bullet_pos,
    input  logic [1:0]  bullet_color,
    output logic [15:0] player_pos,
    output logic        frame_tick,
    output logic        hit,
    output logic        heal,
    output logic        invuln
);

    localparam int               CNT_W    = $clog2(IFRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IFRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [2:0]       vs_q;
    logic             frame_tick_q;
    logic [1:0]       state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic [15:0]      pos_q, pos_d;
    logic             moved_q, moved_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_ready_q;
    logic             hit_q, hit_d;
    logic             heal_q, heal_d;
    logic             invuln_q;

    logic [7:0] x_nxt_s, y_nxt_s;
    logic       x_chg_s, y_chg_s;
    logic [8:0] dx_s, dy_s;
    logic [7:0] half_s;
    logic       overlap_s, hit_c_s, heal_c_s;

    axis_step_clamp #(.LO(MIN_POS), .HI(MAX_POS), .STEP(STEP)) u_x (
        .pos_i      (pos_q[15:8]),
        .inc_i      (pend_q[P_R]),
        .dec_i      (pend_q[P_L]),
        .next_pos_o (x_nxt_s),
        .changed_o  (x_chg_s)
    );

    axis_step_clamp #(.LO(MIN_POS), .HI(MAX_POS), .STEP(STEP)) u_y (
        .pos_i      (pos_q[7:0]),
        .inc_i      (pend_q[P_D]),
        .dec_i      (pend_q[P_U]),
        .next_pos_o (y_nxt_s),
        .changed_o  (y_chg_s)
    );

    // Collision test of the already-updated heart position against the bullet
    always_comb begin
        dx_s = abs_diff(pos_q[15:8], bullet_pos[15:8]);
        dy_s = abs_diff(pos_q[7:0], bullet_pos[7:0]);
        if (bullet_color == COL_BLUE) begin
            half_s = BLUE_HALF;
        end else begin
            half_s = HIT_HALF;
        end
        overlap_s = bullet_active && (dx_s <= {1'b0, half_s}) && (dy_s <= {1'b0, half_s});
        hit_c_s  = 1'b0;
        heal_c_s = 1'b0;
        case (bullet_color)
            COL_WHITE: hit_c_s  = overlap_s && (cnt_q == CNT_ZERO);
            COL_GREEN: heal_c_s = overlap_s;
            COL_BLUE:  hit_c_s  = overlap_s && moved_q && (cnt_q == CNT_ZERO);
            default: begin
                hit_c_s  = 1'b0;
                heal_c_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: key capture, frame FSM and invulnerability countdown
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        pos_d   = pos_q;
        moved_d = moved_q;
        hit_d   = 1'b0;
        heal_d  = 1'b0;

        if (frame_tick_q && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (key_valid && key_ready_q) begin
            case (key_code)
                KEY_W:   pend_d[P_U] = 1'b1;
                KEY_S:   pend_d[P_D] = 1'b1;
                KEY_A:   pend_d[P_L] = 1'b1;
                KEY_D:   pend_d[P_R] = 1'b1;
                default: pend_d = pend_q;
            endcase
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_OFF:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (frame_tick_q) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_MOVE: begin
                pos_d   = {x_nxt_s, y_nxt_s};
                moved_d = x_chg_s || y_chg_s;
                pend_d  = 4'b0000;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                hit_d  = hit_c_s;
                heal_d = heal_c_s;
                if (hit_c_s) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    cnt_d = cnt_d;
                end
                state_d = ST_WAIT;
            end
            default: state_d = ST_OFF;
        endcase

        // Leaving the fight phase discards everything, including a pulse in flight
        if (!enable) begin
            state_d = ST_OFF;
            pend_d  = 4'b0000;
            pos_d   = {START_X, START_Y};
            moved_d = 1'b0;
            cnt_d   = CNT_ZERO;
            hit_d   = 1'b0;
            heal_d  = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q         <= 3'b000;
            frame_tick_q <= 1'b0;
            state_q      <= ST_OFF;
            pend_q       <= 4'b0000;
            pos_q        <= {START_X, START_Y};
            moved_q      <= 1'b0;
            cnt_q        <= CNT_ZERO;
            key_ready_q  <= 1'b0;
            hit_q        <= 1'b0;
            heal_q       <= 1'b0;
            invuln_q     <= 1'b0;
        end else begin
            vs_q         <= {vs_q[1:0], vsync};
            frame_tick_q <= vs_q[1] & ~vs_q[2];
            state_q      <= state_d;
            pend_q       <= pend_d;
            pos_q        <= pos_d;
            moved_q      <= moved_d;
            cnt_q        <= cnt_d;
            key_ready_q  <= (state_d == ST_WAIT);
            hit_q        <= hit_d;
            heal_q       <= heal_d;
            invuln_q     <= (cnt_d != CNT_ZERO);
        end
    end

    assign key_ready  = key_ready_q;
    assign player_pos = pos_q;
    assign frame_tick = frame_tick_q;
    assign hit        = hit_q;
    assign heal       = heal_q;
    assign invuln     = invuln_q;

endmodule
